alu_operand_sequencer: RTL and testbench

Upstream issue stage for `alu_final`. It accepts operation requests whose two operands may arrive in separate beats. It pairs each operand with its partner inside a bounded window, then drives one single-cycle issue into the ALU port set (`OPA`, `OPB`, `CMD`, `MODE`, `CIN`, `CE`, `INP_VALID`). It tracks ALU latency so downstream logic gets a `RES_VALID` strobe aligned with the ALU result registers.

---
 rtl/alu_operand_sequencer_if.sv | 34 +++
 rtl/alu_operand_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - request-side and ALU-side signal bundle for alu_operand_sequencer
interface alu_operand_sequencer_if #(
  parameter int width_OP  = 8,
  parameter int width_cmd = 4
);
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [1:0]           IN_SEL;
  logic [width_OP-1:0]  IN_OPA;
  logic [width_OP-1:0]  IN_OPB;
  logic [width_cmd-1:0] IN_CMD;
  logic                 IN_MODE;
  logic                 IN_CIN;
  logic [width_OP-1:0]  OPA;
  logic [width_OP-1:0]  OPB;
  logic [width_cmd-1:0] CMD;
  logic                 MODE;
  logic                 CIN;
  logic                 CE;
  logic [1:0]           INP_VALID;
  logic                 RES_VALID;
  logic                 TIMEOUT_ERR;
  logic                 BUSY;

  modport slave (
    input  IN_VALID, IN_SEL, IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN,
    output IN_READY, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, RES_VALID, TIMEOUT_ERR, BUSY
  );

  modport master (
    output IN_VALID, IN_SEL, IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN,
    input  IN_READY, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, RES_VALID, TIMEOUT_ERR, BUSY
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - pairs split operand beats and issues them to alu_final with result tracking
// Optional macro ALU_MUL_LAT_EN: multiply commands (MODE=1, CMD=9/10) wait one extra result cycle.
module alu_operand_sequencer #(
  parameter int width_OP  = 8,
  parameter int width_cmd = 4,
  parameter int TIMEOUT   = 16
) (
  input logic                    CLK,
  input logic                    RST,
  alu_operand_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT_RES} state_t;

  state_t               state_q;
  logic [width_OP-1:0]  hold_a_q, hold_b_q, opa_q, opb_q;
  logic [width_cmd-1:0] hold_cmd_q, cmd_q;
  logic                 hold_mode_q, hold_cin_q, mode_q, cin_q;
  logic [1:0]           mask_q, inp_valid_q;
  logic [7:0]           win_q;
  logic [1:0]           lat_q;
  logic                 ready_q, ce_q, res_valid_q, terr_q, busy_q;

  logic                 accept_d, complete_d, expire_d, mul_d;
  logic [1:0]           sel_d, mask_d;
  logic [width_OP-1:0]  a_d, b_d;

  always_comb begin
    accept_d   = bus.IN_VALID & ready_q;
    sel_d      = accept_d ? bus.IN_SEL : 2'b00;
    mask_d     = mask_q | sel_d;
    a_d        = sel_d[0] ? bus.IN_OPA : hold_a_q;
    b_d        = sel_d[1] ? bus.IN_OPB : hold_b_q;
    complete_d = (mask_d == 2'b11);
    expire_d   = (win_q == 8'(TIMEOUT - 1));
  end

`ifdef ALU_MUL_LAT_EN
  localparam logic [width_cmd-1:0] CMD_MUL  = width_cmd'(9);
  localparam logic [width_cmd-1:0] CMD_MULS = width_cmd'(10);
  assign mul_d = mode_q & ((cmd_q == CMD_MUL) | (cmd_q == CMD_MULS));
`else
  assign mul_d = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hold_cmd_q  <= '0;
      hold_mode_q <= 1'b0;
      hold_cin_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      mask_q      <= 2'b00;
      inp_valid_q <= 2'b00;
      win_q       <= 8'd0;
      lat_q       <= 2'd0;
      ready_q     <= 1'b0;
      ce_q        <= 1'b0;
      res_valid_q <= 1'b0;
      terr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ce_q        <= 1'b0;
      inp_valid_q <= 2'b00;
      terr_q      <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (sel_d == 2'b11) begin
            opa_q       <= bus.IN_OPA;
            opb_q       <= bus.IN_OPB;
            cmd_q       <= bus.IN_CMD;
            mode_q      <= bus.IN_MODE;
            cin_q       <= bus.IN_CIN;
            ce_q        <= 1'b1;
            inp_valid_q <= 2'b11;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (sel_d != 2'b00) begin
            hold_a_q    <= a_d;
            hold_b_q    <= b_d;
            hold_cmd_q  <= bus.IN_CMD;
            hold_mode_q <= bus.IN_MODE;
            hold_cin_q  <= bus.IN_CIN;
            mask_q      <= sel_d;
            win_q       <= 8'd0;
            busy_q      <= 1'b1;
            state_q     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          win_q    <= win_q + 8'd1;
          hold_a_q <= a_d;
          hold_b_q <= b_d;
          mask_q   <= mask_d;
          // A completing beat in the expiry cycle takes priority over the timeout.
          if (complete_d || expire_d) begin
            opa_q       <= mask_d[0] ? a_d : opa_q;
            opb_q       <= mask_d[1] ? b_d : opb_q;
            cmd_q       <= hold_cmd_q;
            mode_q      <= hold_mode_q;
            cin_q       <= hold_cin_q;
            ce_q        <= 1'b1;
            inp_valid_q <= mask_d;
            terr_q      <= ~complete_d;
            ready_q     <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_q   <= mul_d ? 2'd3 : 2'd2;
          state_q <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          // lat_q counts the WAIT_RES cycles still ahead, including the current one.
          lat_q       <= lat_q - 2'd1;
          res_valid_q <= (lat_q == 2'd2);
          if (lat_q == 2'd1) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY    = ready_q;
  assign bus.OPA         = opa_q;
  assign bus.OPB         = opb_q;
  assign bus.CMD         = cmd_q;
  assign bus.MODE        = mode_q;
  assign bus.CIN         = cin_q;
  assign bus.CE          = ce_q;
  assign bus.INP_VALID   = inp_valid_q;
  assign bus.RES_VALID   = res_valid_q;
  assign bus.TIMEOUT_ERR = terr_q;
  assign bus.BUSY        = busy_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer (honours ALU_MUL_LAT_EN)
module tb_alu_operand_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int TO = 16;
`ifdef ALU_MUL_LAT_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_operand_sequencer_if #(.width_OP(W), .width_cmd(CW)) bus ();
  alu_operand_sequencer #(.width_OP(W), .width_cmd(CW), .TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n;
  int rate;
  logic v;
  logic [1:0] sel;

  // Transaction-level reference: timestamps of the open request, the issue and the next free cycle.
  int free_at, first_cyc, issue_cyc, res_cyc;
  bit open_op, have_issue;
  logic [1:0] got;
  logic [W-1:0] ha, hb, e_opa, e_opb;
  logic [CW-1:0] hcmd, e_cmd;
  logic hmode, hcin, e_mode, e_cin, e_terr;
  logic [1:0] e_mask;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] cmd;
    logic          mode;
    logic          cin;
    logic [W-1:0]  exp_opa;
    logic [W-1:0]  exp_opb;
    int            exp_lat;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int op_lat(input logic [CW-1:0] cmd, input logic mode);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : 2;
  endfunction

  task automatic model_reset();
    open_op = 0; have_issue = 0; got = 2'b00;
    e_opa = '0; e_opb = '0; e_cmd = '0; e_mode = 0; e_cin = 0; e_mask = 2'b00; e_terr = 0;
    free_at = 1 << 30;
  endtask

  task automatic schedule(input logic [1:0] mask, input logic terr);
    int lat;
    lat = op_lat(hcmd, hmode);
    issue_cyc = cyc + 1;
    res_cyc = issue_cyc + lat;
    free_at = res_cyc + 1;
    have_issue = 1;
    if (mask[0]) e_opa = ha;
    if (mask[1]) e_opb = hb;
    e_cmd = hcmd; e_mode = hmode; e_cin = hcin; e_mask = mask; e_terr = terr;
  endtask

  task automatic check_outputs();
    bit ce_e;
    ce_e = have_issue && (cyc == issue_cyc);
    chk("IN_READY", 32'(bus.IN_READY), 32'(RST && (cyc >= free_at)));
    chk("BUSY", 32'(bus.BUSY), 32'(open_op || (have_issue && cyc >= issue_cyc && cyc < free_at)));
    chk("CE", 32'(bus.CE), 32'(ce_e));
    chk("INP_VALID", 32'(bus.INP_VALID), 32'(ce_e ? e_mask : 2'b00));
    chk("TIMEOUT_ERR", 32'(bus.TIMEOUT_ERR), 32'(ce_e && e_terr));
    chk("RES_VALID", 32'(bus.RES_VALID), 32'(have_issue && cyc == res_cyc));
    chk("OPA", 32'(bus.OPA), 32'(e_opa));
    chk("OPB", 32'(bus.OPB), 32'(e_opb));
    chk("CMD", 32'(bus.CMD), 32'(e_cmd));
    chk("MODE", 32'(bus.MODE), 32'(e_mode));
    chk("CIN", 32'(bus.CIN), 32'(e_cin));
  endtask

  task automatic model_step(input logic vv, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [CW-1:0] cmd, input logic mode, input logic cin);
    bit rdy;
    rdy = RST && (cyc >= free_at);
    if (rdy && vv) begin
      if (!open_op) begin
        if (s != 2'b00) begin
          if (s[0]) ha = a;
          if (s[1]) hb = b;
          hcmd = cmd; hmode = mode; hcin = cin; got = s;
          if (s == 2'b11) schedule(2'b11, 1'b0);
          else begin open_op = 1; first_cyc = cyc; end
        end
      end else begin
        if (s[0]) ha = a;
        if (s[1]) hb = b;
        got = got | s;
        if (got == 2'b11) begin schedule(2'b11, 1'b0); open_op = 0; end
      end
    end
    if (open_op && cyc == first_cyc + TO) begin
      schedule(got, 1'b1);
      open_op = 0;
    end
  endtask

  task automatic step(input logic vv, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [CW-1:0] cmd, input logic mode, input logic cin);
    bus.IN_VALID = vv; bus.IN_SEL = s; bus.IN_OPA = a; bus.IN_OPB = b;
    bus.IN_CMD = cmd; bus.IN_MODE = mode; bus.IN_CIN = cin;
    @(negedge CLK);
    check_outputs();
    model_step(vv, s, a, b, cmd, mode, cin);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int cnt);
    for (int k = 0; k < cnt; k++)
      step(1'b0, 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.IN_READY && k < 20) begin idle(1); k++; end
    chk("wait_ready", 32'(bus.IN_READY), 32'd1);
  endtask

  task automatic do_reset(input int cnt);
    RST = 1'b0;
    model_reset();
    #1;
    chk("rst_ce", 32'(bus.CE), 32'd0);
    chk("rst_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_res", 32'(bus.RES_VALID), 32'd0);
    chk("rst_opa", 32'(bus.OPA), 32'd0);
    chk("rst_iv", 32'(bus.INP_VALID), 32'd0);
    @(posedge CLK);
    #1;
    cyc++;
    idle(cnt);
    RST = 1'b1;
    free_at = cyc + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d: got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h12, 8'h34, 4'd0,  1'b1, 1'b0, 8'h12, 8'h34, 2};
    tbl[1] = '{8'hAA, 8'h55, 4'd9,  1'b1, 1'b0, 8'hAA, 8'h55, MUL_LAT};
    tbl[2] = '{8'h01, 8'hFF, 4'd10, 1'b1, 1'b1, 8'h01, 8'hFF, MUL_LAT};
    tbl[3] = '{8'h80, 8'h7F, 4'd9,  1'b0, 1'b0, 8'h80, 8'h7F, 2};
    tbl[4] = '{8'hFF, 8'h00, 4'd11, 1'b1, 1'b1, 8'hFF, 8'h00, 2};
    tbl[5] = '{8'h3C, 8'hC3, 4'd8,  1'b1, 1'b0, 8'h3C, 8'hC3, 2};

    bus.IN_VALID = 0; bus.IN_SEL = 0; bus.IN_OPA = 0; bus.IN_OPB = 0;
    bus.IN_CMD = 0; bus.IN_MODE = 0; bus.IN_CIN = 0;
    model_reset();
    ha = '0; hb = '0; hcmd = '0; hmode = 0; hcin = 0;
    @(posedge CLK);
    #1;
    do_reset(3);
    idle(2);

    for (int i = 0; i < 6; i++) begin
      wait_ready();
      step(1'b1, 2'b11, tbl[i].a, tbl[i].b, tbl[i].cmd, tbl[i].mode, tbl[i].cin);
      chk("tbl_ce", 32'(bus.CE), 32'd1);
      chk("tbl_iv", 32'(bus.INP_VALID), 32'd3);
      chk("tbl_opa", 32'(bus.OPA), 32'(tbl[i].exp_opa));
      chk("tbl_opb", 32'(bus.OPB), 32'(tbl[i].exp_opb));
      chk("tbl_ready", 32'(bus.IN_READY), 32'd0);
      n = 0;
      while (!bus.RES_VALID && n < 8) begin idle(1); n++; end
      chk("tbl_lat", 32'(n), 32'(tbl[i].exp_lat));
    end

    // Split operands: A then B four cycles later, command from the first beat.
    wait_ready();
    step(1'b1, 2'b01, 8'h0F, 8'hEE, 4'd5, 1'b1, 1'b1);
    idle(3);
    step(1'b1, 2'b10, 8'hDD, 8'hF0, 4'd7, 1'b0, 1'b0);
    chk("split_ce", 32'(bus.CE), 32'd1);
    chk("split_iv", 32'(bus.INP_VALID), 32'd3);
    chk("split_cmd", 32'(bus.CMD), 32'd5);
    chk("split_mode", 32'(bus.MODE), 32'd1);
    chk("split_terr", 32'(bus.TIMEOUT_ERR), 32'd0);
    chk("split_opa", 32'(bus.OPA), 32'h0F);
    chk("split_opb", 32'(bus.OPB), 32'hF0);

    // Timeout: lone A forces a partial issue TIMEOUT+1 cycles after acceptance.
    wait_ready();
    step(1'b1, 2'b01, 8'h55, 8'h00, 4'd2, 1'b0, 1'b0);
    n = 0;
    while (!bus.CE && n < 40) begin idle(1); n++; end
    chk("to_lat", 32'(n), 32'(TO));
    chk("to_iv", 32'(bus.INP_VALID), 32'd1);
    chk("to_terr", 32'(bus.TIMEOUT_ERR), 32'd1);
    chk("to_opa", 32'(bus.OPA), 32'h55);
    chk("to_opb_hold", 32'(bus.OPB), 32'hF0);

    // Race: B lands in the last window cycle, completion wins.
    wait_ready();
    step(1'b1, 2'b01, 8'h66, 8'h00, 4'd3, 1'b1, 1'b0);
    idle(TO - 1);
    step(1'b1, 2'b10, 8'h00, 8'h99, 4'd0, 1'b0, 1'b0);
    chk("race_ce", 32'(bus.CE), 32'd1);
    chk("race_iv", 32'(bus.INP_VALID), 32'd3);
    chk("race_terr", 32'(bus.TIMEOUT_ERR), 32'd0);
    chk("race_opb", 32'(bus.OPB), 32'h99);

    // Held operand re-sent before completion overwrites the earlier value.
    wait_ready();
    step(1'b1, 2'b01, 8'h11, 8'h00, 4'd1, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 2'b01, 8'h22, 8'h00, 4'd6, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 2'b10, 8'h00, 8'h33, 4'd4, 1'b1, 1'b0);
    chk("ovw_opa", 32'(bus.OPA), 32'h22);
    chk("ovw_cmd", 32'(bus.CMD), 32'd1);

    // Empty beat in IDLE is dropped.
    wait_ready();
    step(1'b1, 2'b00, 8'h77, 8'h77, 4'd0, 1'b0, 1'b0);
    chk("empty_busy", 32'(bus.BUSY), 32'd0);
    chk("empty_ready", 32'(bus.IN_READY), 32'd1);

    // Reset during WAIT_RES aborts the operation without a result strobe.
    wait_ready();
    step(1'b1, 2'b11, 8'h44, 8'h45, 4'd1, 1'b1, 1'b0);
    idle(1);
    do_reset(2);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.RES_VALID) n++;
      idle(1);
    end
    chk("abort_nores", 32'(n), 32'd0);
    wait_ready();
    step(1'b1, 2'b11, 8'hA5, 8'h5A, 4'd2, 1'b0, 1'b1);
    chk("abort_next_ce", 32'(bus.CE), 32'd1);
    chk("abort_next_opa", 32'(bus.OPA), 32'hA5);
    idle(4);

    rate = 4;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(1, 8);
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        v = ($urandom_range(1, 8) <= rate);
        sel = 2'($urandom);
        step(v, sel, 8'($urandom), 8'($urandom), 4'($urandom_range(8, 11)), 1'($urandom), 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
